// File: rtl/cellrv32_package.sv
// Shared types for the vector-memory store request queue: the request entry
// layout and the bus-side FSM states.
package cellrv32_package;

    localparam int VMU_ST_ADDR_W = 32;
    localparam int VMU_ST_DATA_W = 32;

    typedef struct packed {
        logic [VMU_ST_ADDR_W-1:0] addr;
        logic [VMU_ST_DATA_W-1:0] data;
    } vmu_st_req_t;

    typedef enum logic [1:0] {
        IDLE,
        STB,
        WAIT
    } vmu_st_q_state_e;

endpackage

// File: rtl/vmu_st_fifo.sv
// vmu_st_fifo: DEPTH-entry in-order FIFO of store requests. Pointers carry an
// extra wrap bit so full and empty are told apart without a separate counter.
// Pushes are refused while full even when a pop happens in the same cycle.
module vmu_st_fifo
    import cellrv32_package::*;
#(
    parameter type entry_t = vmu_st_req_t,
    parameter int  DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  entry_t               push_data_i,
    input  logic                 pop_i,
    output entry_t               head_o,
    output entry_t               next_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign next_o  = mem_q[rd_ptr_q[AW-1:0] + AW'(1)];

    // Next-state for storage and pointers: write at the tail, advance on push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Register storage and pointers; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vmu_st_req_queue.sv
// vmu_st_req_queue: buffers single-element stores from the vector store engine
// and retires them in order over the strobe/ack CPU data bus, with busy/empty
// and sticky error status for fence logic.
// Optional bus-wait timeout enabled by defining CELLRV32_VMU_ST_TIMEOUT_EN.
module vmu_st_req_queue
    import cellrv32_package::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_en_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    output logic                    grant_o,
    output logic                    bus_stb_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    input  logic                    bus_ack_i,
    input  logic                    bus_err_i,
    output logic                    empty_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    input  logic                    err_clr_i
);

    localparam int PW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t            push_entry;
    req_t            head_entry;
    req_t            next_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [PW-1:0]   fifo_count;
    logic            xfer_done;
    logic            xfer_fail;
    logic            timeout;

    vmu_st_q_state_e       state_q, state_d;
    logic                  stb_q, stb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    assign push_entry = '{addr: req_addr_i, data: req_data_i};

    vmu_st_fifo #(
        .entry_t (req_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_en_i),
        .push_data_i (push_entry),
        .pop_i       (xfer_done),
        .head_o      (head_entry),
        .next_o      (next_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef CELLRV32_VMU_ST_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Count WAIT cycles from zero; abort when the count reaches the limit
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == STB) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (state_q == WAIT) & ~bus_ack_i & ~bus_err_i
                   & (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES));

    // Register the wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Ack/err only matter in WAIT; ack together with err is treated as an error
    assign xfer_done = (state_q == WAIT) & (bus_ack_i | bus_err_i | timeout);
    assign xfer_fail = (state_q == WAIT) & (bus_err_i | timeout);

    // Bus FSM: load the head entry when entering STB, strobe for one cycle, then wait
    always_comb begin
        state_d    = state_q;
        stb_d      = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d = STB;
                    stb_d   = 1'b1;
                    addr_d  = head_entry.addr;
                    wdata_d = head_entry.data;
                end
            end
            STB: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (xfer_done) begin
                    if (fifo_count > PW'(1)) begin
                        state_d = STB;
                        stb_d   = 1'b1;
                        addr_d  = next_entry.addr;
                        wdata_d = next_entry.data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (xfer_fail) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Register FSM state, bus outputs and error status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stb_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign grant_o     = ~fifo_full;
    assign bus_stb_o   = stb_q;
    assign bus_we_o    = stb_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = '1;
    assign empty_o     = fifo_empty & (state_q == IDLE);
    assign busy_o      = ~empty_o;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_vmu_st_req_queue.sv
// tb_vmu_st_req_queue: directed bench with a scoreboard of expected bus writes.
// Expected entries are queued when a request is granted and compared when the
// DUT strobes the bus. A built-in responder acks (or errors) in the WAIT cycle.
// Build with CELLRV32_VMU_ST_TIMEOUT_EN to exercise the bus timeout.
module tb_vmu_st_req_queue;

`ifdef CELLRV32_VMU_ST_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_en_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic        grant_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_i = 1'b0;
    logic        empty_o;
    logic        busy_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i = 1'b0;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          stb_count = 0;
    bit          resp_enable = 1'b1;
    bit          force_ack = 1'b0;
    bit          err_match_en = 1'b0;
    logic [31:0] err_match_addr = '0;
    bit          waiting = 1'b0;
    logic [31:0] wait_addr = '0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    vmu_st_req_queue #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_en_i    (req_en_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .grant_o     (grant_o),
        .bus_stb_o   (bus_stb_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_be_o    (bus_be_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .empty_o     (empty_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs on the falling edge: check any strobe against the scoreboard and drive the responder
    task automatic serviceBus();
        exp_t e;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        if (!rst_n) begin
            waiting = 1'b0;
        end else begin
            if (force_ack) begin
                bus_ack_i = 1'b1;
                force_ack = 1'b0;
            end
            if (bus_stb_o) begin
                stb_count++;
                checkOutput("sb_has_entry", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("bus_addr", 64'(bus_addr_o), 64'(e.addr));
                    checkOutput("bus_wdata", 64'(bus_wdata_o), 64'(e.data));
                    checkOutput("bus_be", 64'(bus_be_o), 64'hF);
                    checkOutput("bus_we", 64'(bus_we_o), 64'd1);
                end
                waiting   = 1'b1;
                wait_addr = bus_addr_o;
            end else if (waiting && resp_enable) begin
                if (err_match_en && (wait_addr == err_match_addr)) begin
                    bus_err_i = 1'b1;
                end else begin
                    bus_ack_i = 1'b1;
                end
                waiting = 1'b0;
            end
        end
    endtask

    // One clock: service the bus at the falling edge, return 1 unit after the rising edge
    task automatic tick();
        @(negedge clk);
        serviceBus();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; queue its expectation once the DUT grants it
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        int guard;
        guard      = 0;
        req_en_i   = 1'b1;
        req_addr_i = addr;
        req_data_i = data;
        while (!grant_o && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("grant_wait", 64'(grant_o), 64'd1);
        sb.push_back('{addr: addr, data: data});
        tick();
        req_en_i = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (!(empty_o && sb.size() == 0) && n < bound) begin
            tick();
            n++;
        end
        checkOutput("drain_done", 64'(empty_o && sb.size() == 0), 64'd1);
    endtask

    // Absolute time guard so a broken DUT can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int stb_before;

        // Reset values
        #1;
        checkOutput("rst_stb", 64'(bus_stb_o), 64'd0);
        checkOutput("rst_we", 64'(bus_we_o), 64'd0);
        checkOutput("rst_addr", 64'(bus_addr_o), 64'd0);
        checkOutput("rst_wdata", 64'(bus_wdata_o), 64'd0);
        checkOutput("rst_grant", 64'(grant_o), 64'd1);
        checkOutput("rst_empty", 64'(empty_o), 64'd1);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_err_addr", 64'(err_addr_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single store: strobe appears the cycle after the edge following the push
        $display("[TB] single store");
        applyStimulus(32'h1000, 32'hDEAD_BEEF);
        checkOutput("single_no_stb_yet", 64'(bus_stb_o), 64'd0);
        checkOutput("single_busy", 64'(busy_o), 64'd1);
        tick();
        checkOutput("single_stb", 64'(bus_stb_o), 64'd1);
        checkOutput("single_addr", 64'(bus_addr_o), 64'h1000);
        checkOutput("single_wdata", 64'(bus_wdata_o), 64'hDEAD_BEEF);
        checkOutput("single_be", 64'(bus_be_o), 64'hF);
        tick();
        checkOutput("single_wait_not_empty", 64'(empty_o), 64'd0);
        tick();
        checkOutput("single_empty_after_ack", 64'(empty_o), 64'd1);
        checkOutput("single_busy_after_ack", 64'(busy_o), 64'd0);

        // Ack raised during the strobe cycle must be ignored
        $display("[TB] ack during STB");
        applyStimulus(32'h1004, 32'h1234_5678);
        tick();
        checkOutput("stbak_stb", 64'(bus_stb_o), 64'd1);
        resp_enable = 1'b0;
        force_ack   = 1'b1;
        tick();
        checkOutput("stbak_ignored", 64'(empty_o), 64'd0);
        tick();
        checkOutput("stbak_wait_holds", 64'(empty_o), 64'd0);
        resp_enable = 1'b1;
        waitIdle(20);

        // Fill with the bus stalled, then release one ack and push a fifth request
        $display("[TB] fill and backpressure");
        resp_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'(i * 4), 32'hA000_0000 + 32'(i));
        end
        checkOutput("fill_grant_low", 64'(grant_o), 64'd0);
        req_en_i    = 1'b1;
        req_addr_i  = 32'h10;
        req_data_i  = 32'hA000_0004;
        resp_enable = 1'b1;
        tick();
        checkOutput("fill_grant_after_ack", 64'(grant_o), 64'd1);
        sb.push_back('{addr: 32'h10, data: 32'hA000_0004});
        tick();
        req_en_i = 1'b0;
        waitIdle(60);

        // Stream of stores with zero-wait acks; pointers wrap more than once
        $display("[TB] wrap-around stream");
        stb_before = stb_count;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h100 + 32'(i * 4), $urandom);
        end
        waitIdle(100);
        checkOutput("stream_count", 64'(stb_count - stb_before), 64'd10);

        // Bus error on the middle store of three
        $display("[TB] bus error");
        err_match_en   = 1'b1;
        err_match_addr = 32'h2004;
        applyStimulus(32'h2000, 32'h0000_2000);
        applyStimulus(32'h2004, 32'h0000_2004);
        applyStimulus(32'h2008, 32'h0000_2008);
        waitIdle(60);
        checkOutput("err_set", 64'(err_o), 64'd1);
        checkOutput("err_addr", 64'(err_addr_o), 64'h2004);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("err_cleared", 64'(err_o), 64'd0);
        checkOutput("err_addr_held", 64'(err_addr_o), 64'h2004);

        // Clear and a new error on the same edge: the error wins
        err_match_addr = 32'h3000;
        applyStimulus(32'h3000, 32'h0000_3000);
        tick();
        checkOutput("errclr_stb", 64'(bus_stb_o), 64'd1);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("errclr_err_wins", 64'(err_o), 64'd1);
        checkOutput("errclr_addr", 64'(err_addr_o), 64'h3000);
        checkOutput("errclr_empty", 64'(empty_o), 64'd1);
        err_match_en = 1'b0;

        // Reset in the middle of a WAIT with two entries queued
        $display("[TB] reset mid-WAIT");
        resp_enable = 1'b0;
        applyStimulus(32'h4000, 32'h0000_4000);
        applyStimulus(32'h4004, 32'h0000_4004);
        tick();
        checkOutput("mid_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_stb", 64'(bus_stb_o), 64'd0);
        checkOutput("mid_rst_addr", 64'(bus_addr_o), 64'd0);
        checkOutput("mid_rst_wdata", 64'(bus_wdata_o), 64'd0);
        checkOutput("mid_rst_grant", 64'(grant_o), 64'd1);
        checkOutput("mid_rst_empty", 64'(empty_o), 64'd1);
        checkOutput("mid_rst_err", 64'(err_o), 64'd0);
        checkOutput("mid_rst_err_addr", 64'(err_addr_o), 64'd0);
        sb.delete();
        tick();
        rst_n       = 1'b1;
        stb_before  = stb_count;
        force_ack   = 1'b1;
        resp_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("post_rst_empty", 64'(empty_o), 64'd1);
        checkOutput("post_rst_grant", 64'(grant_o), 64'd1);
        checkOutput("post_rst_err", 64'(err_o), 64'd0);
        checkOutput("post_rst_no_stb", 64'(stb_count - stb_before), 64'd0);

`ifdef CELLRV32_VMU_ST_TIMEOUT_EN
        // Unanswered transfer is aborted after eight WAIT cycles
        $display("[TB] bus timeout");
        resp_enable = 1'b0;
        applyStimulus(32'h5000, 32'h0000_5000);
        tick();
        checkOutput("to_stb", 64'(bus_stb_o), 64'd1);
        n = 0;
        while (!empty_o && n < 50) begin
            tick();
            n++;
        end
        checkOutput("to_wait_cycles", 64'(n - 1), 64'd8);
        checkOutput("to_err", 64'(err_o), 64'd1);
        checkOutput("to_err_addr", 64'(err_addr_o), 64'h5000);
`else
        // Without the timeout the FSM waits for the bus indefinitely
        $display("[TB] no timeout");
        resp_enable = 1'b0;
        applyStimulus(32'h5000, 32'h0000_5000);
        n = 0;
        while (n < 120) begin
            tick();
            n++;
        end
        checkOutput("hold_busy", 64'(busy_o), 64'd1);
        checkOutput("hold_err", 64'(err_o), 64'd0);
        checkOutput("hold_grant", 64'(grant_o), 64'd1);
        resp_enable = 1'b1;
        waitIdle(10);
        checkOutput("hold_err_after_ack", 64'(err_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmu_st_req_queue.md
Name: vmu_st_req_queue

Overview:
- Sits directly downstream of the vector store engine.
- Accepts single-element store requests (address plus one data word) through a req_en/grant handshake and buffers them in a small in-order FIFO.
- Drains the FIFO onto the CPU data bus using a strobe/ack protocol.
- Reports busy, empty and sticky-error status so vector sync/fence logic knows when all stores have retired.

Parameters:
ADDR_WIDTH, 32, request/bus address width
DATA_WIDTH, 32, store data width; multiple of 8
DEPTH, 4, FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 255, bus wait cycles before abort (used only with the optional feature)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
req_en_i  in  1  store request valid from store engine
req_addr_i  in  ADDR_WIDTH  store address
req_data_i  in  DATA_WIDTH  store data
grant_o  out  1  request accepted this cycle when req_en_i is high
bus_stb_o  out  1  one-cycle bus request strobe
bus_we_o  out  1  write enable; equals bus_stb_o
bus_addr_o  out  ADDR_WIDTH  head-entry address
bus_wdata_o  out  DATA_WIDTH  head-entry data
bus_be_o  out  DATA_WIDTH/8  byte enables
bus_ack_i  in  1  bus transfer complete
bus_err_i  in  1  bus transfer error
empty_o  out  1  FIFO empty and FSM in IDLE
busy_o  out  1  inverse of empty_o
err_o  out  1  sticky store-error flag
err_addr_o  out  ADDR_WIDTH  address of the most recent failed store
err_clr_i  in  1  clears err_o

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FIFO pointers 0, count 0, state IDLE.
  - bus_stb_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0.
  - err_o=0, err_addr_o=0, grant_o=1, empty_o=1, busy_o=0.
- Reset mid-operation abandons any outstanding bus transfer and discards all entries.
- Pointers are $clog2(DEPTH)+1 bits, so wrap-around is distinguished by the MSB.
  - full = pointers equal except MSB.
  - empty = pointers fully equal.
- grant_o = ~full. It is combinational from registered state only and never depends on req_en_i.
- Push: on the edge where req_en_i & grant_o, write {req_addr_i, req_data_i} at wr_ptr and increment it.
- When full, no push is accepted, even in the same cycle as a pop. The next request is granted the following cycle.
- FSM states IDLE, STB, WAIT:
  - IDLE: if count!=0, go to STB.
  - STB: bus_stb_o=bus_we_o=1 for exactly this cycle; go to WAIT.
  - WAIT: on bus_ack_i or bus_err_i, pop the head. If count>1 at that edge, go to STB; otherwise go to IDLE.
  - WAIT with neither ack nor err: hold.
- ack and err in the same cycle count as an error.
- bus_ack_i/bus_err_i are ignored outside WAIT, including in the STB cycle.
- bus_addr_o/bus_wdata_o are registered copies of the head entry, loaded on entry to STB and held stable through WAIT.
- bus_be_o is all ones.
- Latency: a request pushed at edge N with an empty FIFO gives bus_stb_o high in the cycle after edge N+1.
  - With a zero-wait-state ack, back-to-back throughput is one store per 2 cycles.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Error handling:
  - bus_err_i in WAIT drops the entry, sets err_o and loads err_addr_o with bus_addr_o.
  - err_clr_i clears err_o. A simultaneous new error wins over the clear (err_o stays 1, err_addr_o updates).
  - Queue operation continues after an error.
- empty_o = (count==0) & (state==IDLE). busy_o = ~empty_o.

Optional Feature:
- Macro: CELLRV32_VMU_ST_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When it equals TIMEOUT_CYCLES without ack/err, the transfer is treated exactly as bus_err_i: pop, set err_o, capture err_addr_o, then leave WAIT.
  - Any later bus_ack_i for that transfer is ignored outside WAIT.
- Undefined: no counter is instantiated, and WAIT holds indefinitely until ack or err.

Decomposition:
- Shared package cellrv32_package:
  - typedef struct vmu_st_req_t {addr, data}.
  - enum vmu_st_q_state_e {IDLE, STB, WAIT}.
- One natural sub-module: vmu_st_fifo, a parameterised DEPTH-entry FIFO of vmu_st_req_t with push/pop, full/empty and count outputs.
- The FSM, bus output registers and error logic stay in vmu_st_req_queue.

Test Plan:
- Single store: push addr 0x1000, data 0xDEADBEEF at edge N; ack in the cycle after STB.
  - bus_stb_o high in the cycle after edge N+1, with addr 0x1000, wdata 0xDEADBEEF, be 0xF.
  - empty_o returns to 1 after the ack edge.
- Fill and backpressure: hold bus_ack_i=0 and push 4 requests.
  - grant_o drops to 0 after the 4th push.
  - After one ack, grant_o=1 the next cycle, and the 5th request enters without loss.
  - Bus order is 0x00, 0x04, 0x08, 0x0C, 0x10.
- Wrap-around: stream 10 stores with zero-wait-state acks.
  - All 10 appear in order with matching data.
  - Pointers wrap twice with no corruption.
- Bus error: bus_err_i on the 2nd of 3 stores (addr 0x2004).
  - err_o=1 and err_addr_o=0x2004; the 3rd store still issues.
  - err_clr_i asserted together with a new error on addr 0x3000 leaves err_o=1 and err_addr_o=0x3000.
- Reset mid-WAIT: assert rst_n=0 with 2 entries queued.
  - All outputs go to reset values immediately.
  - An ack after reset is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=8): no ack after STB.
  - Exactly 8 WAIT cycles, then err_o=1, the entry is popped and the FSM returns to IDLE.
  - With the macro undefined, the FSM remains in WAIT for 100+ cycles.
